// File: rtl/low_fir_mac.sv
// Multiply-accumulate FIR engine: convolves one sequencing burst of samples with an
// external coefficient ROM and emits one clamped Q1.15 result with a one-cycle valid strobe.
module low_fir_mac #(
   parameter int unsigned NUM_TAPS = 1021,
   parameter int unsigned ACC_W    = 42
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sequencing,
   input  logic signed [15:0]            smpl_in,
   output logic [$clog2(NUM_TAPS)-1:0]   coeff_addr,
   input  logic signed [15:0]            coeff,
   output logic signed [15:0]            smpl_out,
   output logic                          valid,
   output logic                          sat
);

   localparam int unsigned AW = $clog2(NUM_TAPS);
   localparam int unsigned CW = $clog2(NUM_TAPS + 1);

   localparam logic [CW-1:0] TapMax  = CW'(NUM_TAPS);
   localparam logic [AW-1:0] AddrMax = AW'(NUM_TAPS - 1);

   localparam logic signed [ACC_W-1:0] PosMax = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] NegMin = -(ACC_W'(32768));

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StDrain,
      StDone,
      StBusy
   } state_e;

   state_e                    state_q;
   logic [CW-1:0]             tap_cnt_q;
   logic [CW-1:0]             tap_inc;
   logic [1:0]                flush_q;
   logic                      tap_fire;
   logic                      v1_q;
   logic                      v2_q;
   logic signed [31:0]        mult;
   logic signed [31:0]        prod_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   acc_shr;

   // Taps past the table end keep reading the last entry but are never accumulated.
   assign coeff_addr = (tap_cnt_q >= TapMax) ? AddrMax : tap_cnt_q[AW-1:0];
   assign tap_inc    = (tap_cnt_q >= TapMax) ? TapMax : tap_cnt_q + 1'b1;
   assign tap_fire   = ((state_q == StIdle) || (state_q == StRun)) && sequencing &&
                       (tap_cnt_q < TapMax);
   assign mult       = smpl_in * coeff;
   assign acc_shr    = acc_q >>> 15;

   // Burst-tracking FSM; a rise in DRAIN/DONE is parked in BUSY until sequencing drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         tap_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sequencing) begin
                  state_q   <= StRun;
                  tap_cnt_q <= tap_inc;
               end
            end
            StRun: begin
               if (sequencing) begin
                  tap_cnt_q <= tap_inc;
               end else begin
                  state_q   <= StDrain;
                  tap_cnt_q <= '0;
               end
            end
            StDrain: begin
               if (sequencing) begin
                  state_q <= StBusy;
               end else if (flush_q == 2'd1) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= sequencing ? StBusy : StIdle;
            end
            StBusy: begin
               if (!sequencing) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q   <= StIdle;
               tap_cnt_q <= '0;
            end
         endcase
      end
   end

   // Flush countdown runs independently of the FSM so a rejected burst cannot cancel the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q <= '0;
      end else if ((state_q == StRun) && !sequencing) begin
         flush_q <= 2'd2;
      end else if (flush_q != 2'd0) begin
         flush_q <= flush_q - 2'd1;
      end
   end

   // Two-stage MAC pipeline with a tap-valid bit riding alongside each product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         v1_q <= tap_fire;
         v2_q <= v1_q;
         if (v1_q) begin
            prod_q <= mult;
         end
         if ((state_q == StIdle) && sequencing) begin
            acc_q <= '0;
         end else if (v2_q) begin
            acc_q <= acc_q + ACC_W'(prod_q);
         end
      end
   end

   // Output register: floor-scaled, clamped result with its saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smpl_out <= '0;
         sat      <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= (flush_q == 2'd1);
         if (flush_q == 2'd1) begin
            if (acc_shr > PosMax) begin
               smpl_out <= 16'sh7FFF;
               sat      <= 1'b1;
            end else if (acc_shr < NegMin) begin
               smpl_out <= -16'sh8000;
               sat      <= 1'b1;
            end else begin
               smpl_out <= acc_shr[15:0];
               sat      <= 1'b0;
            end
         end
      end
   end

endmodule
